// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: breathing sequencer issuing top/compare load strobes to a pwm block
module pwm_fade_ctrl #(
  parameter int RESOLUTION = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic [RESOLUTION-1:0] i_top,
  input  logic [RESOLUTION:0]   i_step,
  input  logic [DIV_WIDTH-1:0]  i_step_div,
  input  logic [DIV_WIDTH-1:0]  i_hold_hi,
  input  logic [DIV_WIDTH-1:0]  i_hold_lo,
  output logic [RESOLUTION-1:0] o_top,
  output logic                  o_top_valid,
  output logic [RESOLUTION:0]   o_compare,
  output logic                  o_compare_valid,
  output logic [2:0]            o_state,
  output logic                  o_cycle_done
);
  localparam int CW = RESOLUTION + 1;
  typedef enum logic [2:0] {IDLE = 3'd0, RISE = 3'd1, HOLD_HI = 3'd2, FALL = 3'd3, HOLD_LO = 3'd4} state_t;
  state_t                state, state_n;
  logic [RESOLUTION-1:0] top_sh, top_n;
  logic [CW-1:0]         step_sh, cmp_n;
  logic [DIV_WIDTH-1:0]  div_sh, hh_sh, hl_sh, presc, presc_n, hold_cnt, hold_n;
  logic                  tv_n, cv_n, done_n, sample, tick;
  logic [CW-1:0]         step_eff, max_val, rise_val, fall_val;
  logic [CW:0]           sum;
  assign o_state  = state;
  assign step_eff = (step_sh == '0) ? CW'(1) : step_sh;
  assign max_val  = {1'b0, top_sh} + 1'b1;
  assign sum      = {1'b0, o_compare} + {1'b0, step_eff};
  // the extra sum bit keeps a large step from wrapping past the ceiling
  assign rise_val = (sum >= {1'b0, max_val}) ? max_val : sum[CW-1:0];
  assign fall_val = (o_compare <= step_eff) ? '0 : o_compare - step_eff;
  assign tick     = presc == div_sh;
  always_comb begin
    state_n = state;
    top_n   = o_top;
    cmp_n   = o_compare;
    presc_n = presc;
    hold_n  = hold_cnt;
    tv_n    = 1'b0;
    cv_n    = 1'b0;
    done_n  = 1'b0;
    sample  = 1'b0;
    if (state == IDLE) begin
      if (i_enable) begin
        state_n = RISE;
        sample  = 1'b1;
        top_n   = i_top;
        cmp_n   = '0;
        tv_n    = 1'b1;
        cv_n    = 1'b1;
        presc_n = '0;
        hold_n  = '0;
      end
    end else if (!i_enable) begin
      state_n = IDLE;
      cmp_n   = '0;
      cv_n    = 1'b1;
      presc_n = '0;
      hold_n  = '0;
    end else begin
      presc_n = tick ? '0 : presc + 1'b1;
      if (tick) begin
        case (state)
          RISE: begin
            cmp_n = rise_val;
            cv_n  = 1'b1;
            if (rise_val == max_val) begin
              state_n = HOLD_HI;
              hold_n  = '0;
            end
          end
          HOLD_HI: begin
            state_n = (hold_cnt == hh_sh) ? FALL : HOLD_HI;
            hold_n  = (hold_cnt == hh_sh) ? hold_cnt : hold_cnt + 1'b1;
          end
          FALL: begin
            cmp_n = fall_val;
            cv_n  = 1'b1;
            if (fall_val == '0) begin
              state_n = HOLD_LO;
              hold_n  = '0;
            end
          end
          HOLD_LO: begin
            if (hold_cnt == hl_sh) begin
              state_n = RISE;
              sample  = 1'b1;
              top_n   = i_top;
              tv_n    = 1'b1;
              done_n  = 1'b1;
              hold_n  = '0;
            end else begin
              hold_n = hold_cnt + 1'b1;
            end
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      o_top           <= '0;
      o_compare       <= '0;
      o_top_valid     <= 1'b0;
      o_compare_valid <= 1'b0;
      o_cycle_done    <= 1'b0;
      presc           <= '0;
      hold_cnt        <= '0;
      top_sh          <= '0;
      step_sh         <= '0;
      div_sh          <= '0;
      hh_sh           <= '0;
      hl_sh           <= '0;
    end else begin
      state           <= state_n;
      o_top           <= top_n;
      o_compare       <= cmp_n;
      o_top_valid     <= tv_n;
      o_compare_valid <= cv_n;
      o_cycle_done    <= done_n;
      presc           <= presc_n;
      hold_cnt        <= hold_n;
      if (sample) begin
        top_sh  <= i_top;
        step_sh <= i_step;
        div_sh  <= i_step_div;
        hh_sh   <= i_hold_hi;
        hl_sh   <= i_hold_lo;
      end
    end
  end
endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb_pwm_fade_ctrl: directed literal checks plus randomized run against a behavioural model
module tb_pwm_fade_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [7:0]  top = '0, o_top;
  logic [8:0]  step = '0, o_compare;
  logic [15:0] sdiv = '0, hh = '0, hl = '0;
  logic        o_top_valid, o_compare_valid, o_cycle_done;
  logic [2:0]  o_state;
  int n_chk = 0, n_fail = 0, cyc = 0, n_done = 0;
  int cq[$], ct[$];
  always #5 clk = ~clk;
  pwm_fade_ctrl #(.RESOLUTION(8), .DIV_WIDTH(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_top(top), .i_step(step),
    .i_step_div(sdiv), .i_hold_hi(hh), .i_hold_lo(hl),
    .o_top(o_top), .o_top_valid(o_top_valid), .o_compare(o_compare),
    .o_compare_valid(o_compare_valid), .o_state(o_state), .o_cycle_done(o_cycle_done)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  // model: phase 0 idle, 1 rise, 2 hold high, 3 fall, 4 hold low
  int m_phase = 0, m_cmp = 0, m_top = 0, m_since = 0, m_hold = 0;
  int s_top = 0, s_step = 0, s_div = 0, s_hh = 0, s_hl = 0;
  int m_tv = 0, m_cv = 0, m_done = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_cmp = 0; m_top = 0; m_since = 0; m_hold = 0;
      s_top = 0; s_step = 0; s_div = 0; s_hh = 0; s_hl = 0;
      m_tv = 0; m_cv = 0; m_done = 0;
    end else begin
      int st, mx;
      cyc++;
      m_tv = 0; m_cv = 0; m_done = 0;
      st = (s_step == 0) ? 1 : s_step;
      mx = s_top + 1;
      if (m_phase == 0) begin
        if (en) begin
          s_top = int'(top); s_step = int'(step); s_div = int'(sdiv); s_hh = int'(hh); s_hl = int'(hl);
          m_phase = 1; m_top = int'(top); m_cmp = 0; m_tv = 1; m_cv = 1; m_since = 0; m_hold = 0;
        end
      end else if (!en) begin
        m_phase = 0; m_cmp = 0; m_cv = 1; m_since = 0; m_hold = 0;
      end else if (m_since != s_div) begin
        m_since++;
      end else begin
        m_since = 0;
        if (m_phase == 1) begin
          m_cmp = (m_cmp + st > mx) ? mx : m_cmp + st;
          m_cv = 1;
          if (m_cmp == mx) begin m_phase = 2; m_hold = 0; end
        end else if (m_phase == 2) begin
          if (m_hold == s_hh) m_phase = 3; else m_hold++;
        end else if (m_phase == 3) begin
          m_cmp = (m_cmp <= st) ? 0 : m_cmp - st;
          m_cv = 1;
          if (m_cmp == 0) begin m_phase = 4; m_hold = 0; end
        end else if (m_hold == s_hl) begin
          s_top = int'(top); s_step = int'(step); s_div = int'(sdiv); s_hh = int'(hh); s_hl = int'(hl);
          m_phase = 1; m_top = int'(top); m_tv = 1; m_done = 1; m_hold = 0;
        end else begin
          m_hold++;
        end
      end
    end
  end
  always @(negedge clk) begin
    chk("state", 32'(o_state), m_phase);
    chk("compare", 32'(o_compare), m_cmp);
    chk("top", 32'(o_top), m_top);
    chk("top_valid", 32'(o_top_valid), m_tv);
    chk("compare_valid", 32'(o_compare_valid), m_cv);
    chk("cycle_done", 32'(o_cycle_done), m_done);
    if (o_compare_valid === 1'b1) begin cq.push_back(int'(o_compare)); ct.push_back(cyc); end
    if (o_cycle_done === 1'b1) n_done++;
  end
  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask
  task automatic cfg(input int t, input int s, input int d, input int h1, input int h0);
    top = 8'(t); step = 9'(s); sdiv = 16'(d); hh = 16'(h1); hl = 16'(h0);
  endtask
  task automatic wait_state(input int s, input int lim, input string nm);
    int k = 0;
    while (32'(o_state) != s && k < lim) begin cycles(1); k++; end
    chk({nm, "_timeout"}, 32'(k < lim), 1);
  endtask
  task automatic chk_seq(input string nm, input int e[$]);
    chk({nm, "_len"}, 32'(cq.size() >= e.size()), 1);
    foreach (e[i]) if (i < cq.size()) chk($sformatf("%s[%0d]", nm, i), cq[i], e[i]);
  endtask
  initial begin
    int e[$];
    int k, tvc;
    cycles(2);
    chk("rst_state", 32'(o_state), 0);
    chk("rst_compare", 32'(o_compare), 0);
    chk("rst_top", 32'(o_top), 0);
    rst_n = 1'b1;
    cycles(1);
    // ramp 64 per 4 clocks to 256 and back
    cfg(255, 64, 3, 0, 0);
    cq.delete(); ct.delete(); n_done = 0; en = 1'b1;
    cycles(45);
    e = {0, 64, 128, 192, 256, 192, 128, 64, 0};
    chk_seq("ramp64", e);
    if (ct.size() > 2) chk("ramp64_spacing", ct[2] - ct[1], 4);
    chk("ramp64_done", n_done, 1);
    en = 1'b0; cycles(2);
    // async reset in the middle of a rise
    en = 1'b1; k = 0;
    while (o_compare !== 9'h40 && k < 30) begin cycles(1); k++; end
    chk("rst_mid_reach", 32'(k < 30), 1);
    rst_n = 1'b0; #1;
    chk("rst_mid_compare", 32'(o_compare), 0);
    chk("rst_mid_state", 32'(o_state), 0);
    chk("rst_mid_strobes", {29'd0, o_top_valid, o_compare_valid, o_cycle_done}, 0);
    en = 1'b0; cycles(1); rst_n = 1'b1; cycles(1);
    // saturation at MAX=100
    cfg(99, 30, 0, 2, 2);
    cq.delete(); ct.delete(); en = 1'b1;
    cycles(14);
    e = {0, 30, 60, 90, 100, 70, 40, 10, 0};
    chk_seq("sat100", e);
    en = 1'b0; cycles(2);
    // step 0 behaves as 1, one update per clock
    cfg(3, 0, 0, 0, 0);
    cq.delete(); ct.delete(); en = 1'b1;
    cycles(12);
    e = {0, 1, 2, 3, 4, 3, 2, 1, 0};
    chk_seq("step0", e);
    if (ct.size() > 4) chk("step0_rate", ct[4] - ct[1], 3);
    en = 1'b0; cycles(2);
    // disable during HOLD_HI
    cfg(255, 300, 1, 10, 0);
    en = 1'b1;
    wait_state(2, 40, "hold_hi");
    en = 1'b0; cycles(1);
    chk("dis_state", 32'(o_state), 0);
    chk("dis_compare", 32'(o_compare), 0);
    chk("dis_cv", 32'(o_compare_valid), 1);
    cycles(1);
    chk("dis_cv_single", 32'(o_compare_valid), 0);
    // top change mid-fall is deferred to the next breath
    cfg(255, 64, 1, 1, 1);
    en = 1'b1;
    wait_state(3, 100, "fall");
    top = 8'd127; tvc = 0; k = 0;
    while (o_cycle_done !== 1'b1 && k < 200) begin
      cycles(1); k++;
      if (o_top_valid === 1'b1 && o_cycle_done !== 1'b1) tvc++;
    end
    chk("newtop_reach", 32'(k < 200), 1);
    chk("newtop_early_tv", tvc, 0);
    chk("newtop_tv", 32'(o_top_valid), 1);
    chk("newtop_top", 32'(o_top), 127);
    wait_state(2, 100, "newtop_hold");
    chk("newtop_max", 32'(o_compare), 128);
    en = 1'b0; cycles(2);
    // randomized run
    for (int s = 0; s < 6; s++) begin
      cfg(($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : $urandom_range(0, 255),
          $urandom_range(0, 300), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      en = 1'b1;
      for (int c = 0; c < 500; c++) begin
        if ($urandom_range(0, 7) == 0)
          cfg($urandom_range(0, 255), $urandom_range(0, 511), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
        if ($urandom_range(0, 149) == 0) en = ~en;
        cycles(1);
      end
    end
    en = 1'b0; cycles(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
